// File: rtl/sd_img_pkg.sv
// Shared constants for the SD image loader: sector geometry and FSM state codes.
package sd_img_pkg;

  localparam int SECTOR_BYTES     = 512;
  localparam int WORDS_PER_SECTOR = 256;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_STREAM    = 3'd3;
  localparam logic [2:0] ST_CHUNK_END = 3'd4;
  localparam logic [2:0] ST_RETRY     = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_FAIL      = 3'd7;

endpackage

// File: rtl/byte_packer.sv
// Packs the reader byte stream into 16-bit RAM words (first byte high) with a registered write port.
module byte_packer #(
  parameter int ADDR_W    = 17,
  parameter int IMG_WORDS = 76800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  logic [31:0]       word_base,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data
);

  logic              hi_full_q, hi_full_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]       ram_data_q, ram_data_d;
  logic [31:0]       word_addr;

  always_comb begin
    hi_full_d  = hi_full_q;
    hi_byte_d  = hi_byte_q;
    word_idx_d = word_idx_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    word_addr  = word_base + 32'(word_idx_q);
    if (clear) begin
      // a dangling high byte from an aborted chunk is dropped here
      hi_full_d  = 1'b0;
      word_idx_d = '0;
    end else if (byte_valid) begin
      if (!hi_full_q) begin
        hi_byte_d = byte_in;
        hi_full_d = 1'b1;
      end else begin
        hi_full_d  = 1'b0;
        word_idx_d = word_idx_q + 16'd1;
        if (word_addr < 32'(IMG_WORDS)) begin
          ram_we_d   = 1'b1;
          ram_addr_d = word_addr[ADDR_W-1:0];
          ram_data_d = {hi_byte_q, byte_in};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_full_q  <= 1'b0;
      hi_byte_q  <= '0;
      word_idx_q <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      hi_full_q  <= hi_full_d;
      hi_byte_q  <= hi_byte_d;
      word_idx_q <= word_idx_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;

endmodule

// File: rtl/sd_image_loader.sv
// Sequences sd_card_reader in multi-block chunks to copy one image slot into frame RAM port A.
//  state     | meaning
//  IDLE      | waiting for load_req
//  ISSUE     | compute chunk sector/count, pulse sd_start_read
//  WAIT_BUSY | wait for reader busy, bounded by START_TIMEOUT
//  STREAM    | accept bytes until busy falls
//  CHUNK_END | verify byte count, advance or retry
//  RETRY     | bump retry count, rewind chunk or give up
//  DONE      | flag loaded
//  FAIL      | flag load_error
module sd_image_loader
  import sd_img_pkg::*;
#(
  parameter int ADDR_W        = 17,
  parameter int IMG_WORDS     = 76800,
  parameter int IMG_SECTORS   = 300,
  parameter int CHUNK_BLOCKS  = 16,
  parameter int BASE_SECTOR   = 0,
  parameter int SLOT_STRIDE   = 512,
  parameter int START_TIMEOUT = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [1:0]        image_select,
  output logic              sd_start_read,
  output logic [31:0]       sd_sector_addr,
  output logic [7:0]        sd_block_count,
  input  logic [7:0]        sd_data_in,
  input  logic              sd_data_valid,
  input  logic              sd_busy,
  input  logic              sd_error,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_we,
  output logic              loading,
  output logic              loaded,
  output logic              load_error,
  output logic [1:0]        cur_image
);

  localparam int TMR_W  = $clog2(START_TIMEOUT + 1);
  localparam int RTRY_W = $clog2(MAX_RETRY + 2);
  localparam int BCNT_W = 18;

  if (IMG_WORDS > (2 ** ADDR_W)) begin : g_addr_w_chk
    $error("IMG_WORDS does not fit the RAM address width");
  end
  if (CHUNK_BLOCKS < 1 || CHUNK_BLOCKS > 255) begin : g_chunk_chk
    $error("CHUNK_BLOCKS must be 1..255");
  end

  logic [2:0]        state_q, state_d;
  logic [1:0]        cur_image_q, cur_image_d;
  logic [31:0]       slot_base_q, slot_base_d;
  logic [31:0]       sectors_done_q, sectors_done_d;
  logic [31:0]       chunk_word_base_q, chunk_word_base_d;
  logic [31:0]       sector_addr_q, sector_addr_d;
  logic [7:0]        block_count_q, block_count_d;
  logic              start_read_q, start_read_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [RTRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              loading_q, loading_d;
  logic              loaded_q, loaded_d;
  logic              load_error_q, load_error_d;

  logic              pack_clear;
  logic              pack_valid;
  logic [31:0]       remaining;
  logic [BCNT_W-1:0] chunk_bytes;

  always_comb begin
    state_d           = state_q;
    cur_image_d       = cur_image_q;
    slot_base_d       = slot_base_q;
    sectors_done_d    = sectors_done_q;
    chunk_word_base_d = chunk_word_base_q;
    sector_addr_d     = sector_addr_q;
    block_count_d     = block_count_q;
    start_read_d      = 1'b0;
    timer_d           = timer_q;
    retry_cnt_d       = retry_cnt_q;
    byte_cnt_d        = byte_cnt_q;
    loading_d         = loading_q;
    loaded_d          = loaded_q;
    load_error_d      = load_error_q;
    pack_clear        = 1'b0;
    pack_valid        = 1'b0;
    remaining         = 32'(IMG_SECTORS) - sectors_done_q;
    chunk_bytes       = {1'b0, block_count_q, 9'd0};

    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          cur_image_d    = image_select;
          slot_base_d    = 32'(BASE_SECTOR) + 32'(image_select) * 32'(SLOT_STRIDE);
          loaded_d       = 1'b0;
          load_error_d   = 1'b0;
          loading_d      = 1'b1;
          sectors_done_d = '0;
          retry_cnt_d    = '0;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        block_count_d     = (remaining < 32'(CHUNK_BLOCKS)) ? remaining[7:0] : 8'(CHUNK_BLOCKS);
        sector_addr_d     = slot_base_q + sectors_done_q;
        chunk_word_base_d = sectors_done_q * 32'(WORDS_PER_SECTOR);
        start_read_d      = 1'b1;
        timer_d           = TMR_W'(START_TIMEOUT - 1);
        byte_cnt_d        = '0;
        pack_clear        = 1'b1;
        state_d           = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (sd_error) begin
          state_d = ST_RETRY;
        end else if (sd_busy) begin
          state_d = ST_STREAM;
        end else if (timer_q == '0) begin
          state_d = ST_RETRY;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_STREAM: begin
        if (sd_error) begin
          state_d = ST_RETRY;
        end else begin
          // a byte arriving with the busy fall is still counted before the check
          if (sd_data_valid) begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            pack_valid = 1'b1;
          end
          if (!sd_busy) state_d = ST_CHUNK_END;
        end
      end
      ST_CHUNK_END: begin
        if (byte_cnt_q == chunk_bytes) begin
          sectors_done_d = sectors_done_q + 32'(block_count_q);
          retry_cnt_d    = '0;
          state_d        = (sectors_done_d == 32'(IMG_SECTORS)) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_RETRY;
        end
      end
      ST_RETRY: begin
        retry_cnt_d = retry_cnt_q + RTRY_W'(1);
        byte_cnt_d  = '0;
        pack_clear  = 1'b1;
        state_d     = (32'(retry_cnt_d) > 32'(MAX_RETRY)) ? ST_FAIL : ST_ISSUE;
      end
      ST_DONE: begin
        loading_d = 1'b0;
        loaded_d  = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_FAIL: begin
        loading_d    = 1'b0;
        load_error_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      cur_image_q       <= '0;
      slot_base_q       <= '0;
      sectors_done_q    <= '0;
      chunk_word_base_q <= '0;
      sector_addr_q     <= '0;
      block_count_q     <= '0;
      start_read_q      <= 1'b0;
      timer_q           <= '0;
      retry_cnt_q       <= '0;
      byte_cnt_q        <= '0;
      loading_q         <= 1'b0;
      loaded_q          <= 1'b0;
      load_error_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      cur_image_q       <= cur_image_d;
      slot_base_q       <= slot_base_d;
      sectors_done_q    <= sectors_done_d;
      chunk_word_base_q <= chunk_word_base_d;
      sector_addr_q     <= sector_addr_d;
      block_count_q     <= block_count_d;
      start_read_q      <= start_read_d;
      timer_q           <= timer_d;
      retry_cnt_q       <= retry_cnt_d;
      byte_cnt_q        <= byte_cnt_d;
      loading_q         <= loading_d;
      loaded_q          <= loaded_d;
      load_error_q      <= load_error_d;
    end
  end

  byte_packer #(
    .ADDR_W    (ADDR_W),
    .IMG_WORDS (IMG_WORDS)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_in    (sd_data_in),
    .word_base  (chunk_word_base_q),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data)
  );

  assign sd_start_read  = start_read_q;
  assign sd_sector_addr = sector_addr_q;
  assign sd_block_count = block_count_q;
  assign loading        = loading_q;
  assign loaded         = loaded_q;
  assign load_error     = load_error_q;
  assign cur_image      = cur_image_q;

endmodule

// File: tb/tb_sd_image_loader.sv
// Bench for sd_image_loader: randomized SD reader model against a sector/offset image reference.
module tb_sd_image_loader;

  localparam int ADDR_W        = 11;
  localparam int IMG_WORDS     = 1700;
  localparam int IMG_SECTORS   = 7;
  localparam int CHUNK_BLOCKS  = 2;
  localparam int BASE_SECTOR   = 100;
  localparam int SLOT_STRIDE   = 512;
  localparam int START_TIMEOUT = 1024;
  localparam int MAX_RETRY     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_req;
  logic [1:0]        image_select;
  logic              sd_start_read;
  logic [31:0]       sd_sector_addr;
  logic [7:0]        sd_block_count;
  logic [7:0]        sd_data_in;
  logic              sd_data_valid;
  logic              sd_busy;
  logic              sd_error;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              ram_we;
  logic              loading;
  logic              loaded;
  logic              load_error;
  logic [1:0]        cur_image;

  always #5 clk = ~clk;

  sd_image_loader #(
    .ADDR_W(ADDR_W), .IMG_WORDS(IMG_WORDS), .IMG_SECTORS(IMG_SECTORS),
    .CHUNK_BLOCKS(CHUNK_BLOCKS), .BASE_SECTOR(BASE_SECTOR), .SLOT_STRIDE(SLOT_STRIDE),
    .START_TIMEOUT(START_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .image_select(image_select),
    .sd_start_read(sd_start_read), .sd_sector_addr(sd_sector_addr),
    .sd_block_count(sd_block_count), .sd_data_in(sd_data_in),
    .sd_data_valid(sd_data_valid), .sd_busy(sd_busy), .sd_error(sd_error),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .loading(loading), .loaded(loaded), .load_error(load_error), .cur_image(cur_image)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference image: byte at (absolute sector, offset); every sector starts 0x12,0x34
  int unsigned seed;
  function automatic logic [7:0] model_byte(input int unsigned sec, input int unsigned off);
    if (off == 0) return 8'h12;
    if (off == 1) return 8'h34;
    return 8'((sec * 37) ^ (off * 11) ^ (off >> 8) ^ seed);
  endfunction

  function automatic logic [15:0] model_word(input int unsigned slot, input int unsigned w);
    int unsigned sec, off;
    sec = BASE_SECTOR + slot * SLOT_STRIDE + w / 256;
    off = 2 * (w % 256);
    return {model_byte(sec, off), model_byte(sec, off + 1)};
  endfunction

  // reader control and logs
  bit no_busy  = 1'b0;
  int drop_cmd = -1;
  int err_cmd  = -1;
  int gap_pct  = 20;
  int cmd_base = 0;
  int cyc      = 0;
  int hold_bad = 0;
  int cmd_sec[$];
  int cmd_cnt[$];
  int cmd_time[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic serve_cmd();
    int s, n, idx;
    s   = int'(sd_sector_addr);
    n   = int'(sd_block_count);
    idx = cmd_sec.size() - cmd_base;
    cmd_sec.push_back(s);
    cmd_cnt.push_back(n);
    cmd_time.push_back(cyc);
    if (no_busy) return;
    sd_busy = 1'b1;
    for (int i = 0; i < n * 512; i++) begin
      @(negedge clk);
      while (rst_n && $urandom_range(0, 99) < gap_pct) begin
        sd_data_valid = 1'b0;
        @(negedge clk);
      end
      if (!rst_n) begin
        sd_busy = 1'b0;
        sd_data_valid = 1'b0;
        return;
      end
      if (idx == err_cmd && i == 300) begin
        sd_data_valid = 1'b0;
        sd_error = 1'b1;
        @(negedge clk);
        sd_error = 1'b0;
        sd_busy = 1'b0;
        return;
      end
      if (int'(sd_sector_addr) != s || int'(sd_block_count) != n) hold_bad++;
      if (idx == drop_cmd && i == 100) begin
        sd_data_valid = 1'b0;
        continue;
      end
      sd_data_valid = 1'b1;
      sd_data_in = model_byte(s + i / 512, i % 512);
      if (i == n * 512 - 1) sd_busy = 1'b0;
    end
    @(negedge clk);
    sd_data_valid = 1'b0;
  endtask

  initial begin
    sd_busy = 1'b0;
    sd_data_valid = 1'b0;
    sd_data_in = '0;
    sd_error = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && sd_start_read) serve_cmd();
    end
  end

  // RAM capture
  logic [15:0] mem [0:2047];
  int mem_stamp [0:2047];
  int load_id = 0;
  int we_cnt  = 0;
  int oob_cnt = 0;
  int wr_cmd[$];
  int wr_addr[$];

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      we_cnt++;
      wr_cmd.push_back(cmd_sec.size());
      wr_addr.push_back(int'(ram_addr));
      if (int'(ram_addr) >= IMG_WORDS) oob_cnt++;
      else begin
        mem[ram_addr] = ram_data;
        mem_stamp[ram_addr] = load_id;
      end
    end
  end

  function automatic int first_wr_after(input int g);
    for (int i = 0; i < wr_cmd.size(); i++)
      if (wr_cmd[i] == g + 1) return wr_addr[i];
    return -1;
  endfunction

  function automatic logic [63:0] outs_cmd();
    return 64'({sd_start_read, sd_sector_addr, sd_block_count});
  endfunction

  function automatic logic [63:0] outs_ram();
    return 64'({ram_addr, ram_data, ram_we, loading, loaded, load_error, cur_image});
  endfunction

  task automatic pulse_load(input int slot);
    image_select = 2'(slot);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    image_select = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!loaded && !load_error && k < 30000) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_timeout"}, 64'(k >= 30000), 0);
  endtask

  task automatic check_cmds(input string tag, input int slot, input int dup, input int cb);
    int es[$];
    int ec[$];
    int done, n;
    done = 0;
    while (done < IMG_SECTORS) begin
      n = (IMG_SECTORS - done < CHUNK_BLOCKS) ? IMG_SECTORS - done : CHUNK_BLOCKS;
      es.push_back(BASE_SECTOR + slot * SLOT_STRIDE + done);
      ec.push_back(n);
      done += n;
    end
    if (dup >= 0) begin
      es.insert(dup + 1, es[dup]);
      ec.insert(dup + 1, ec[dup]);
    end
    check_val({tag, "_ncmd"}, 64'(cmd_sec.size() - cb), 64'(es.size()));
    for (int k = 0; k < es.size() && cb + k < cmd_sec.size(); k++) begin
      check_val($sformatf("%s_sec%0d", tag, k), 64'(cmd_sec[cb + k]), 64'(es[k]));
      check_val($sformatf("%s_cnt%0d", tag, k), 64'(cmd_cnt[cb + k]), 64'(ec[k]));
    end
  endtask

  task automatic check_image(input string tag, input int slot);
    int bad;
    bad = 0;
    for (int w = 0; w < IMG_WORDS; w++)
      if (mem_stamp[w] != load_id || mem[w] !== model_word(slot, w)) bad++;
    check_val({tag, "_image_bad_words"}, 64'(bad), 0);
  endtask

  task automatic begin_load(output int cb, output int wb);
    load_id++;
    seed = $urandom;
    cb = cmd_sec.size();
    cmd_base = cb;
    wb = we_cnt;
  endtask

  initial begin
    int cb, wb, hb, k, slot;
    rst_n = 1'b0;
    load_req = 1'b0;
    image_select = 2'd0;
    repeat (3) @(negedge clk);
    check_val("rst_cmd_outs", outs_cmd(), 0);
    check_val("rst_ram_outs", outs_ram(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // clean load of slot 2
    begin_load(cb, wb);
    hb = hold_bad;
    pulse_load(2);
    check_val("t1_loading", 64'(loading), 1);
    wait_done("t1");
    check_val("t1_flags", 64'({loading, loaded, load_error}), 64'(3'b010));
    check_val("t1_first_sec", 64'(cmd_sec[cb]), 64'(BASE_SECTOR + 2 * SLOT_STRIDE));
    check_val("t1_first_cnt", 64'(cmd_cnt[cb]), 64'(CHUNK_BLOCKS));
    check_val("t1_last_cnt", 64'(cmd_cnt[cmd_cnt.size() - 1]), 1);
    check_cmds("t1", 2, -1, cb);
    check_val("t1_we_count", 64'(we_cnt - wb), 64'(IMG_WORDS));
    check_val("t1_word0", 64'(mem[0]), 64'(16'h1234));
    check_val("t1_cmd_hold", 64'(hold_bad - hb), 0);
    check_val("t1_cur_image", 64'(cur_image), 2);
    check_image("t1", 2);
    repeat (3) @(negedge clk);

    // reader never goes busy
    begin_load(cb, wb);
    no_busy = 1'b1;
    slot = $urandom_range(0, 3);
    pulse_load(slot);
    wait_done("t2");
    no_busy = 1'b0;
    check_val("t2_flags", 64'({loading, loaded, load_error}), 64'(3'b001));
    check_val("t2_ncmd", 64'(cmd_sec.size() - cb), 4);
    for (int i = 0; i < 4 && cb + i < cmd_sec.size(); i++)
      check_val($sformatf("t2_sec%0d", i), 64'(cmd_sec[cb + i]), 64'(BASE_SECTOR + slot * SLOT_STRIDE));
    for (int i = 1; i < 4 && cb + i < cmd_sec.size(); i++) begin
      k = cmd_time[cb + i] - cmd_time[cb + i - 1];
      check_val($sformatf("t2_gap%0d_in_range", i), 64'(k >= START_TIMEOUT && k <= START_TIMEOUT + 6), 1);
    end
    check_val("t2_we_count", 64'(we_cnt - wb), 0);
    repeat (3) @(negedge clk);

    // one byte dropped on chunk 3
    begin_load(cb, wb);
    drop_cmd = 3;
    pulse_load(1);
    wait_done("t3");
    drop_cmd = -1;
    check_val("t3_flags", 64'({loading, loaded, load_error}), 64'(3'b010));
    check_cmds("t3", 1, 3, cb);
    check_val("t3_restart_addr", 64'(first_wr_after(cb + 4)), 64'(6 * 256));
    check_val("t3_we_count", 64'(we_cnt - wb), 64'(IMG_WORDS + (IMG_WORDS - 6 * 256)));
    check_image("t3", 1);
    repeat (3) @(negedge clk);

    // sd_error mid-stream on chunk 0
    begin_load(cb, wb);
    err_cmd = 0;
    pulse_load(0);
    wait_done("t4");
    err_cmd = -1;
    check_val("t4_flags", 64'({loading, loaded, load_error}), 64'(3'b010));
    check_cmds("t4", 0, 0, cb);
    check_val("t4_restart_addr", 64'(first_wr_after(cb + 1)), 0);
    check_val("t4_we_count", 64'(we_cnt - wb), 64'(IMG_WORDS + 150));
    check_image("t4", 0);
    repeat (3) @(negedge clk);

    // load_req while loading is ignored
    begin_load(cb, wb);
    pulse_load(3);
    k = 0;
    while (we_cnt - wb < 100 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check_val("t5_mid_wait_timeout", 64'(k >= 20000), 0);
    pulse_load(1);
    check_val("t5_cur_image_mid", 64'(cur_image), 3);
    check_val("t5_loading_mid", 64'(loading), 1);
    wait_done("t5");
    check_val("t5_flags", 64'({loading, loaded, load_error}), 64'(3'b010));
    check_val("t5_cur_image", 64'(cur_image), 3);
    check_cmds("t5", 3, -1, cb);
    check_image("t5", 3);
    repeat (3) @(negedge clk);

    // reset mid-stream, then a clean load
    begin_load(cb, wb);
    pulse_load(2);
    k = 0;
    while (we_cnt - wb < 200 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check_val("t6_mid_wait_timeout", 64'(k >= 20000), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t6_rst_cmd_outs", outs_cmd(), 0);
    check_val("t6_rst_ram_outs", outs_ram(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    begin_load(cb, wb);
    pulse_load(2);
    wait_done("t6");
    check_val("t6_flags", 64'({loading, loaded, load_error}), 64'(3'b010));
    check_cmds("t6", 2, -1, cb);
    check_val("t6_we_count", 64'(we_cnt - wb), 64'(IMG_WORDS));
    check_image("t6", 2);
    repeat (3) @(negedge clk);

    // random clean loads with random byte gaps
    for (int r = 0; r < 2; r++) begin
      begin_load(cb, wb);
      gap_pct = $urandom_range(0, 50);
      slot = $urandom_range(0, 3);
      pulse_load(slot);
      wait_done($sformatf("t7_%0d", r));
      check_val($sformatf("t7_%0d_flags", r), 64'({loading, loaded, load_error}), 64'(3'b010));
      check_val($sformatf("t7_%0d_cur_image", r), 64'(cur_image), 64'(slot));
      check_cmds($sformatf("t7_%0d", r), slot, -1, cb);
      check_val($sformatf("t7_%0d_we_count", r), 64'(we_cnt - wb), 64'(IMG_WORDS));
      check_image($sformatf("t7_%0d", r), slot);
      repeat (3) @(negedge clk);
    end

    check_val("no_pad_writes", 64'(oob_cnt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
